// File: rtl/fs332_pipe_if.sv
// fs332_pipe_if: operand/result bundle for the 3-operand subtractor.
// Carries both valid/ready handshakes; zero exists only with FS332_ZERO_EN.
//
// Signals:
//   in_valid/in_ready    input handshake (producer -> subtractor)
//   a, b, c, bi0, bi1    minuend, subtrahends and borrow-ins
//   out_valid/out_ready  output handshake (subtractor -> consumer)
//   d, bo0, bo1          difference and borrow-outs
//   zero                 d == 0 (FS332_ZERO_EN only)
// Modports:
//   master  producer/consumer side (drives operands and out_ready)
//   slave   subtractor side
interface fs332_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             bi0;
    logic             bi1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bo0;
    logic             bo1;
`ifdef FS332_ZERO_EN
    logic             zero;

    modport master (
        output in_valid, a, b, c, bi0, bi1, out_ready,
        input  in_ready, out_valid, d, bo0, bo1, zero
    );

    modport slave (
        input  in_valid, a, b, c, bi0, bi1, out_ready,
        output in_ready, out_valid, d, bo0, bo1, zero
    );
`else
    modport master (
        output in_valid, a, b, c, bi0, bi1, out_ready,
        input  in_ready, out_valid, d, bo0, bo1
    );

    modport slave (
        input  in_valid, a, b, c, bi0, bi1, out_ready,
        output in_ready, out_valid, d, bo0, bo1
    );
`endif
endinterface

// File: rtl/fs332_pipe.sv
// fs332_pipe: two-stage pipelined subtractor, d = a - b - c with borrows.
// Optional macro FS332_ZERO_EN adds a registered zero flag (d == 0).
//
// Ports:
//   clk     system clock, rising edge
//   resetl  asynchronous active-low reset
//   bus     fs332_pipe_if.slave: in_valid/in_ready, a/b/c/bi0/bi1,
//           out_valid/out_ready, d/bo0/bo1 (and zero with FS332_ZERO_EN)
//
// Stage 1 computes a - b - bi0 and carries c/bi1 forward.
// Stage 2 computes st - c - bi1; its register drives the outputs.
module fs332_pipe #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        resetl,
    fs332_pipe_if.slave bus
);

    // Handshake advance terms
    logic adv1;
    logic adv2;

    // Stage 1 register
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] st_q,       st_d;
    logic             bo0_s1_q,   bo0_s1_d;
    logic [WIDTH-1:0] c_s1_q,     c_s1_d;
    logic             bi1_s1_q,   bi1_s1_d;

    // Stage 2 register
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] d_q,        d_d;
    logic             bo0_q,      bo0_d;
    logic             bo1_q,      bo1_d;
`ifdef FS332_ZERO_EN
    logic             zero_q,     zero_d;
`endif

    // Extended differences: top bit is the borrow-out
    logic [WIDTH:0] diff1;
    logic [WIDTH:0] diff2;

    // A stage may advance if it is empty or its successor advances,
    // so a full pipe still accepts when the consumer takes the output.
    assign adv2 = !s2_valid_q || bus.out_ready;
    assign adv1 = !s1_valid_q || adv2;

    always_comb begin
        diff1 = {1'b0, bus.a}
              - {1'b0, bus.b}
              - {{WIDTH{1'b0}}, bus.bi0};
    end

    always_comb begin
        diff2 = {1'b0, st_q}
              - {1'b0, c_s1_q}
              - {{WIDTH{1'b0}}, bi1_s1_q};
    end

    // Stage 1 next state: data loads on every advance, valid or not
    always_comb begin
        s1_valid_d = s1_valid_q;
        st_d       = st_q;
        bo0_s1_d   = bo0_s1_q;
        c_s1_d     = c_s1_q;
        bi1_s1_d   = bi1_s1_q;
        if (adv1) begin
            s1_valid_d = bus.in_valid;
            st_d       = diff1[WIDTH-1:0];
            bo0_s1_d   = diff1[WIDTH];
            c_s1_d     = bus.c;
            bi1_s1_d   = bus.bi1;
        end
    end

    // Stage 2 next state
    always_comb begin
        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        bo0_d      = bo0_q;
        bo1_d      = bo1_q;
`ifdef FS332_ZERO_EN
        zero_d     = zero_q;
`endif
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            d_d        = diff2[WIDTH-1:0];
            bo0_d      = bo0_s1_q;
            bo1_d      = diff2[WIDTH];
`ifdef FS332_ZERO_EN
            zero_d     = (diff2[WIDTH-1:0] == '0);
`endif
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            s1_valid_q <= 1'b0;
            st_q       <= '0;
            bo0_s1_q   <= 1'b0;
            c_s1_q     <= '0;
            bi1_s1_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            st_q       <= st_d;
            bo0_s1_q   <= bo0_s1_d;
            c_s1_q     <= c_s1_d;
            bi1_s1_q   <= bi1_s1_d;
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            bo0_q      <= 1'b0;
            bo1_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            bo0_q      <= bo0_d;
            bo1_q      <= bo1_d;
        end
    end

`ifdef FS332_ZERO_EN
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign bus.zero = zero_q;
`endif

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.d         = d_q;
    assign bus.bo0       = bo0_q;
    assign bus.bo1       = bo1_q;

endmodule

// File: tb/tb_fs332_pipe.sv
// tb_fs332_pipe: directed scoreboard bench for fs332_pipe.
// Inputs change after negedge; transfers are judged just before posedge.
module tb_fs332_pipe;

    typedef struct {
        logic [31:0] d;
        logic        bo0;
        logic        bo1;
        logic        z;
    } exp_t;

    logic clk;
    logic resetl;

    fs332_pipe_if #(.WIDTH(32)) bus ();

    fs332_pipe #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetl (resetl),
        .bus    (bus)
    );

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   npop    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic exp_t model(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [31:0] c,
                                   input logic bi0,
                                   input logic bi1);
        exp_t        e;
        logic [31:0] st;
        st    = a - b - 32'(bi0);
        e.bo0 = ({32'd0, a} < ({32'd0, b} + 64'(bi0)));
        e.d   = st - c - 32'(bi1);
        e.bo1 = ({32'd0, st} < ({32'd0, c} + 64'(bi1)));
        e.z   = (e.d == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] c,
                         input logic bi0,
                         input logic bi1);
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.bi0      = bi0;
        bus.bi1      = bi1;
        bus.in_valid = 1'b1;
    endtask

    // One clock: score transfers at the coming edge, then step to negedge
    task automatic cyc();
        exp_t e;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                npop++;
                chk("d", 64'(bus.d), 64'(e.d));
                chk("bo0", 64'(bus.bo0), 64'(e.bo0));
                chk("bo1", 64'(bus.bo1), 64'(e.bo1));
`ifdef FS332_ZERO_EN
                chk("zero", 64'(bus.zero), 64'(e.z));
`endif
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.a, bus.b, bus.c, bus.bi0, bus.bi1));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        bus.in_valid = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int   first;
        int   last;
        int   ov;
        int   p0;
        logic acc;

        resetl        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = '0;
        bus.bi0       = 1'b0;
        bus.bi1       = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_d", 64'(bus.d), 64'd0);
        chk("rst_bo0", 64'(bus.bo0), 64'd0);
        chk("rst_bo1", 64'(bus.bo1), 64'd0);
`ifdef FS332_ZERO_EN
        chk("rst_zero", 64'(bus.zero), 64'd0);
`endif
        resetl = 1'b1;

        // 1: basic subtraction, single-cycle out_valid pulse
        bus.out_ready = 1'b1;
        drive(32'd10, 32'd3, 32'd2, 1'b0, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        chk("t1_lat_s1", 64'(bus.out_valid), 64'd0);
        cyc();
        #1;
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_d_const", 64'(bus.d), 64'd5);
        cyc();
        #1;
        chk("t1_pulse_end", 64'(bus.out_valid), 64'd0);

        // 2: wrap-around borrows
        drive(32'd0, 32'd1, 32'd0, 1'b0, 1'b0);
        cyc();
        drive(32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        cyc();
        drain(6);

        // 3: stage-2 borrow, then exact zero
        drive(32'h10, 32'h8, 32'h8, 1'b0, 1'b1);
        cyc();
        drive(32'h10, 32'h8, 32'h8, 1'b0, 1'b0);
        cyc();
        drain(6);

        // 4: back-to-back stream of 8
        first = -1;
        last  = -1;
        ov    = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                drive($urandom, $urandom, $urandom,
                      1'($urandom_range(1)), 1'($urandom_range(1)));
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            chk("t4_in_ready", 64'(bus.in_ready), 64'd1);
            if (bus.out_valid) begin
                if (first < 0) first = i;
                last = i;
                ov++;
            end
            cyc();
        end
        chk("t4_count", 64'(ov), 64'd8);
        chk("t4_first", 64'(first), 64'd2);
        chk("t4_contig", 64'(last - first), 64'd7);
        drain(4);

        // 5: stall with 3 offered, then release with in_valid held
        bus.out_ready = 1'b0;
        drive(32'd100, 32'd1, 32'd2, 1'b0, 1'b0);
        cyc();
        drive(32'd200, 32'd50, 32'd60, 1'b1, 1'b1);
        #1;
        chk("t5_rdy_1", 64'(bus.in_ready), 64'd1);
        cyc();
        drive(32'd7, 32'd9, 32'd1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_full_rdy", 64'(bus.in_ready), 64'd0);
            chk("t5_hold_vld", 64'(bus.out_valid), 64'd1);
            chk("t5_hold_d", 64'(bus.d), 64'(sb[0].d));
            chk("t5_hold_bo1", 64'(bus.bo1), 64'(sb[0].bo1));
            cyc();
        end
        chk("t5_queued", 64'(sb.size()), 64'd2);
        bus.out_ready = 1'b1;
        p0 = npop;
        for (int k = 0; k < 10; k++) begin
            if (sb.size() == 0 && !bus.in_valid) break;
            #1;
            acc = bus.in_valid && bus.in_ready;
            cyc();
            if (acc) bus.in_valid = 1'b0;
        end
        chk("t5_popped", 64'(npop - p0), 64'd3);
        chk("t5_empty", 64'(sb.size()), 64'd0);

        // 6: asynchronous reset with both stages full
        bus.out_ready = 1'b0;
        drive(32'd55, 32'd5, 32'd5, 1'b0, 1'b0);
        cyc();
        drive(32'd66, 32'd6, 32'd6, 1'b0, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        chk("t6_full_vld", 64'(bus.out_valid), 64'd1);
        chk("t6_full_rdy", 64'(bus.in_ready), 64'd0);
        resetl = 1'b0;
        #1;
        chk("t6_rst_vld", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_d", 64'(bus.d), 64'd0);
        chk("t6_rst_bo0", 64'(bus.bo0), 64'd0);
        chk("t6_rst_rdy", 64'(bus.in_ready), 64'd1);
`ifdef FS332_ZERO_EN
        chk("t6_rst_zero", 64'(bus.zero), 64'd0);
`endif
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        resetl        = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t6_no_stale", 64'(bus.out_valid), 64'd0);
            cyc();
        end

        // Pipe still works after reset
        drive(32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        cyc();
        drain(6);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
